// File: rtl/rho_sequencer.sv
// Rho-step sequencer: reads each of the 25 lanes in turn, rotates it by its rho offset, writes it back.
// Build macro RHO_ZERO_SKIP_EN skips the zero-offset lane (12) with no memory traffic.
module rho_sequencer #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  lane_addr,
    output logic        lane_rd_en,
    input  logic [63:0] lane_rdata,
    output logic        lane_wr_en,
    output logic [63:0] lane_wdata,
    output logic        busy,
    output logic        co
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    localparam logic [4:0] LAST_LANE = 5'd24;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    function automatic logic [5:0] rho_off(input logic [4:0] lane);
        logic [5:0] o;
        case (lane)
            5'd0:    o = 6'd21;
            5'd1:    o = 6'd8;
            5'd2:    o = 6'd41;
            5'd3:    o = 6'd45;
            5'd4:    o = 6'd15;
            5'd5:    o = 6'd56;
            5'd6:    o = 6'd14;
            5'd7:    o = 6'd18;
            5'd8:    o = 6'd2;
            5'd9:    o = 6'd61;
            5'd10:   o = 6'd28;
            5'd11:   o = 6'd27;
            5'd12:   o = 6'd0;
            5'd13:   o = 6'd1;
            5'd14:   o = 6'd62;
            5'd15:   o = 6'd55;
            5'd16:   o = 6'd20;
            5'd17:   o = 6'd36;
            5'd18:   o = 6'd44;
            5'd19:   o = 6'd6;
            5'd20:   o = 6'd25;
            5'd21:   o = 6'd39;
            5'd22:   o = 6'd3;
            5'd23:   o = 6'd10;
            5'd24:   o = 6'd43;
            default: o = 6'd0;
        endcase
        return o;
    endfunction

    // Left rotate: out bit k takes in bit (k - sh) mod 64.
    function automatic logic [63:0] rotl(input logic [63:0] din, input logic [5:0] sh);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            r[k] = din[6'(k) - sh];
        end
        return r;
    endfunction

    function automatic logic [4:0] next_lane(input logic [4:0] lane);
        logic [4:0] n;
        n = lane + 5'd1;
`ifdef RHO_ZERO_SKIP_EN
        if (n == 5'd12) begin
            n = 5'd13;
        end
`endif
        return n;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  lane_q, lane_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] cap_q, cap_d;
    logic [4:0]  addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        co_q, co_d;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    lane_d  = 5'd0;
                    state_d = READ;
                end
            end
            READ: begin
                cnt_d   = 2'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cap_d   = lane_rdata;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WRITE: begin
                if (lane_q == LAST_LANE) begin
                    state_d = DONE;
                end else begin
                    lane_d  = next_lane(lane_q);
                    state_d = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end
        // Strobes are registered against the state being entered so they line up with it.
        rd_d   = (state_d == READ);
        wr_d   = (state_d == WRITE);
        busy_d = (state_d == READ) || (state_d == WAIT) || (state_d == WRITE);
        co_d   = (state_d == DONE);
        if (state_d == READ) begin
            addr_d = lane_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            co_q    <= co_d;
        end
    end

    // An abort arriving in the WRITE or DONE cycle must kill that cycle's strobe.
    assign lane_addr  = addr_q;
    assign lane_rd_en = rd_q;
    assign lane_wr_en = wr_q & ~abort;
    assign lane_wdata = rotl(cap_q, rho_off(lane_q));
    assign busy       = busy_q;
    assign co         = co_q & ~abort;

endmodule

// File: tb/tb_rho_sequencer.sv
// Directed bench for rho_sequencer: one instance at RD_LAT=1, one at RD_LAT=3, behavioural lane memory.
module tb_rho_sequencer;
`ifdef RHO_ZERO_SKIP_EN
    localparam int NL = 24;
`else
    localparam int NL = 25;
`endif
    localparam int P1 = NL * 3;
    localparam int P3 = NL * 5;

    localparam logic [63:0] EXP_L0  = 64'h0000000000200000;
    localparam logic [63:0] EXP_L1  = 64'h0000000000000100;
    localparam logic [63:0] EXP_L2  = 64'h0000020000000000;
    localparam logic [63:0] EXP_L9  = 64'h1000000000000000;
    localparam logic [63:0] EXP_L12 = 64'h0123456789ABCDEF;
    localparam logic [63:0] EXP_L14 = 64'h4000000000000000;
    localparam logic [63:0] EXP_L24 = 64'h0000080000000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start1 = 1'b0, abort1 = 1'b0;
    logic [4:0]  addr1;
    logic        rd1, wr1, busy1, co1;
    logic [63:0] rdata1, wdata1;

    logic        start3 = 1'b0, abort3 = 1'b0;
    logic [4:0]  addr3;
    logic        rd3, wr3, busy3, co3;
    logic [63:0] rdata3, wdata3;

    rho_sequencer #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .lane_addr(addr1), .lane_rd_en(rd1), .lane_rdata(rdata1),
        .lane_wr_en(wr1), .lane_wdata(wdata1), .busy(busy1), .co(co1)
    );

    rho_sequencer #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .lane_addr(addr3), .lane_rd_en(rd3), .lane_rdata(rdata3),
        .lane_wr_en(wr3), .lane_wdata(wdata3), .busy(busy3), .co(co3)
    );

    logic [63:0] mem [0:31];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Lane memory: data valid exactly RD_LAT cycles after the strobe, garbage otherwise.
    logic        v1_q;
    logic [63:0] d1_q;
    logic [2:0]  v3_q;
    logic [63:0] d3_q [0:2];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v3_q <= 3'b0;
        end else begin
            v1_q    <= rd1;
            d1_q    <= mem[addr1];
            v3_q    <= {v3_q[1:0], rd3};
            d3_q[0] <= mem[addr3];
            d3_q[1] <= d3_q[0];
            d3_q[2] <= d3_q[1];
        end
    end
    assign rdata1 = v1_q    ? d1_q    : 64'hDEADBEEFCAFEF00D;
    assign rdata3 = v3_q[2] ? d3_q[2] : 64'hDEADBEEFCAFEF00D;

    int clr_req = 0, clr_ack1 = 0, clr_ack3 = 0;
    int rd_n1, wr_n1, ovl1, spb1, ordb1, busy_n1, co_n1, co_busy1, a12_n1;
    int first_busy1, co_cyc1, last_rd1, last_rda1, last_wa1, first_rda1;
    logic [63:0] wlog1 [0:31];
    logic        wseen1 [0:31];
    int rd_n3, wr_n3, ovl3, spb3, busy_n3, co_n3;
    logic [63:0] wlog3_0;

    always @(negedge clk) begin
        if (clr_ack1 != clr_req) begin
            clr_ack1 = clr_req;
            rd_n1 = 0; wr_n1 = 0; ovl1 = 0; spb1 = 0; ordb1 = 0; busy_n1 = 0;
            co_n1 = 0; co_busy1 = 0; a12_n1 = 0; first_busy1 = -1; co_cyc1 = -1;
            last_rd1 = -100; last_rda1 = -1; last_wa1 = -1; first_rda1 = -1;
            for (int i = 0; i < 32; i++) begin
                wlog1[i] = '0;
                wseen1[i] = 1'b0;
            end
        end else begin
            if (rd1 && wr1) ovl1++;
            if ((rd1 || wr1) && addr1 == 5'd12) a12_n1++;
            if (rd1) begin
                rd_n1++;
                last_rd1 = cyc;
                last_rda1 = int'(addr1);
                if (first_rda1 < 0) first_rda1 = int'(addr1);
            end
            if (wr1) begin
                wr_n1++;
                if (cyc - last_rd1 != 2) spb1++;
                if (int'(addr1) != last_rda1 || int'(addr1) <= last_wa1) ordb1++;
                last_wa1 = int'(addr1);
                wlog1[addr1] = wdata1;
                wseen1[addr1] = 1'b1;
            end
            if (busy1) begin
                busy_n1++;
                if (first_busy1 < 0) first_busy1 = cyc;
            end
            if (co1) begin
                co_n1++;
                co_cyc1 = cyc;
                if (busy1) co_busy1++;
            end
        end
    end

    int last_rd3;
    always @(negedge clk) begin
        if (clr_ack3 != clr_req) begin
            clr_ack3 = clr_req;
            rd_n3 = 0; wr_n3 = 0; ovl3 = 0; spb3 = 0; busy_n3 = 0; co_n3 = 0;
            last_rd3 = -100; wlog3_0 = '0;
        end else begin
            if (rd3 && wr3) ovl3++;
            if (rd3) begin
                rd_n3++;
                last_rd3 = cyc;
            end
            if (wr3) begin
                wr_n3++;
                if (cyc - last_rd3 != 4) spb3++;
                if (addr3 == 5'd0) wlog3_0 = wdata3;
            end
            if (busy3) busy_n3++;
            if (co3) co_n3++;
        end
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic mon_clear();
        clr_req++;
        for (int i = 0; i < 10 && (clr_ack1 != clr_req || clr_ack3 != clr_req); i++) nclk();
    endtask

    task automatic start_pass1();
        mon_clear();
        start1 = 1'b1;
        nclk();
        start1 = 1'b0;
    endtask

    task automatic wait_co1(input string name);
        for (int i = 0; i < 400 && co_n1 == 0; i++) nclk();
        checks++;
        if (co_n1 == 0) begin
            errors++;
            $display("FAIL %s co timeout got %0d pulses want 1", name, co_n1);
        end
        nclk();
    endtask

    task automatic test_reset();
        nclk();
        nclk();
        checks++; if (rd1 !== 1'b0)   begin errors++; $display("FAIL reset_rd got %b want 0", rd1); end
        checks++; if (wr1 !== 1'b0)   begin errors++; $display("FAIL reset_wr got %b want 0", wr1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
        checks++; if (co1 !== 1'b0)   begin errors++; $display("FAIL reset_co got %b want 0", co1); end
        checks++; if (addr1 !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr1); end
        checks++; if (busy3 !== 1'b0 || rd3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got busy %b rd %b want 0 0", busy3, rd3); end
        rst_n = 1'b1;
        nclk();
        nclk();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy1); end
    endtask

    task automatic test_pass();
        start_pass1();
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL pass_busy_first got %b want 1", busy1); end
        checks++; if (rd1 !== 1'b1 || addr1 !== 5'd0) begin errors++; $display("FAIL pass_first_read got rd %b addr %0d want 1 0", rd1, addr1); end
        for (int i = 0; i < 20; i++) nclk();
        start1 = 1'b1;
        nclk();
        start1 = 1'b0;
        wait_co1("pass");
        checks++; if (busy_n1 != P1) begin errors++; $display("FAIL pass_len got %0d want %0d", busy_n1, P1); end
        checks++; if (co_cyc1 - first_busy1 != P1) begin errors++; $display("FAIL co_delay got %0d want %0d", co_cyc1 - first_busy1, P1); end
        checks++; if (co_n1 != 1 || co_busy1 != 0) begin errors++; $display("FAIL co_pulse got %0d pulses %0d with busy want 1 0", co_n1, co_busy1); end
        checks++; if (rd_n1 != NL || wr_n1 != NL) begin errors++; $display("FAIL strobe_count got rd %0d wr %0d want %0d", rd_n1, wr_n1, NL); end
        checks++; if (ovl1 != 0) begin errors++; $display("FAIL rd_wr_overlap got %0d want 0", ovl1); end
        checks++; if (spb1 != 0 || ordb1 != 0) begin errors++; $display("FAIL seq_order got spacing %0d order %0d want 0 0", spb1, ordb1); end
        checks++; if (wlog1[0] !== EXP_L0)   begin errors++; $display("FAIL lane0 got %h want %h", wlog1[0], EXP_L0); end
        checks++; if (wlog1[1] !== EXP_L1)   begin errors++; $display("FAIL lane1 got %h want %h", wlog1[1], EXP_L1); end
        checks++; if (wlog1[2] !== EXP_L2)   begin errors++; $display("FAIL lane2 got %h want %h", wlog1[2], EXP_L2); end
        checks++; if (wlog1[9] !== EXP_L9)   begin errors++; $display("FAIL lane9 got %h want %h", wlog1[9], EXP_L9); end
        checks++; if (wlog1[14] !== EXP_L14) begin errors++; $display("FAIL lane14 got %h want %h", wlog1[14], EXP_L14); end
        checks++; if (wlog1[24] !== EXP_L24) begin errors++; $display("FAIL lane24 got %h want %h", wlog1[24], EXP_L24); end
`ifdef RHO_ZERO_SKIP_EN
        checks++; if (a12_n1 != 0) begin errors++; $display("FAIL lane12_skip got %0d strobes want 0", a12_n1); end
`else
        checks++; if (wseen1[12] !== 1'b1 || wlog1[12] !== EXP_L12) begin errors++; $display("FAIL lane12 got %h want %h", wlog1[12], EXP_L12); end
`endif
        checks++; if (busy1 !== 1'b0 || co1 !== 1'b0) begin errors++; $display("FAIL post_pass got busy %b co %b want 0 0", busy1, co1); end
    endtask

    task automatic test_rdlat3();
        mon_clear();
        start3 = 1'b1;
        nclk();
        start3 = 1'b0;
        for (int i = 0; i < 400 && co_n3 == 0; i++) nclk();
        checks++; if (co_n3 == 0) begin errors++; $display("FAIL lat3 co timeout got 0 want 1"); end
        nclk();
        checks++; if (busy_n3 != P3) begin errors++; $display("FAIL lat3_len got %0d want %0d", busy_n3, P3); end
        checks++; if (co_n3 != 1) begin errors++; $display("FAIL lat3_co got %0d want 1", co_n3); end
        checks++; if (spb3 != 0) begin errors++; $display("FAIL lat3_spacing got %0d bad want 0", spb3); end
        checks++; if (wr_n3 != NL || rd_n3 != NL || ovl3 != 0) begin errors++; $display("FAIL lat3_strobes got rd %0d wr %0d ovl %0d want %0d %0d 0", rd_n3, wr_n3, ovl3, NL, NL); end
        checks++; if (wlog3_0 !== EXP_L0) begin errors++; $display("FAIL lat3_lane0 got %h want %h", wlog3_0, EXP_L0); end
    endtask

    task automatic test_abort();
        start_pass1();
        for (int i = 0; i < 100 && !(rd1 && addr1 == 5'd5); i++) nclk();
        checks++; if (!(rd1 && addr1 == 5'd5)) begin errors++; $display("FAIL abort_find got addr %0d want 5", addr1); end
        @(posedge clk);
        @(posedge clk);
        #1;
        abort1 = 1'b1;
        #1;
        checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL abort_wr got %b want 0", wr1); end
        @(posedge clk);
        #1;
        abort1 = 1'b0;
        nclk();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy1); end
        for (int i = 0; i < 10; i++) nclk();
        checks++; if (wseen1[5] !== 1'b0 || wr_n1 != 5) begin errors++; $display("FAIL abort_writes got lane5 %b count %0d want 0 5", wseen1[5], wr_n1); end
        checks++; if (co_n1 != 0) begin errors++; $display("FAIL abort_co got %0d want 0", co_n1); end
        start_pass1();
        wait_co1("restart");
        checks++; if (first_rda1 != 0) begin errors++; $display("FAIL restart_lane got %0d want 0", first_rda1); end
        checks++; if (wr_n1 != NL || co_n1 != 1) begin errors++; $display("FAIL restart_pass got wr %0d co %0d want %0d 1", wr_n1, co_n1, NL); end
    endtask

    task automatic test_reset_mid();
        start_pass1();
        for (int i = 0; i < 100 && !(rd1 && addr1 == 5'd3); i++) nclk();
        checks++; if (!(rd1 && addr1 == 5'd3)) begin errors++; $display("FAIL rst_find got addr %0d want 3", addr1); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({rd1, wr1, busy1, co1} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b want 0000", {rd1, wr1, busy1, co1}); end
        checks++; if (addr1 !== 5'd0 || wdata1 !== 64'd0) begin errors++; $display("FAIL rst_data got addr %0d wdata %h want 0 0", addr1, wdata1); end
        nclk();
        nclk();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) nclk();
        checks++; if (rd_n1 != 4 || wr_n1 != 3) begin errors++; $display("FAIL rst_no_strobes got rd %0d wr %0d want 4 3", rd_n1, wr_n1); end
        checks++; if (busy1 !== 1'b0 || co_n1 != 0) begin errors++; $display("FAIL rst_idle got busy %b co %0d want 0 0", busy1, co_n1); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'd1;
        mem[9]  = 64'h8000000000000000;
        mem[12] = 64'h0123456789ABCDEF;
        test_reset();
        test_pass();
        test_rdlat3();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rho_sequencer.md
RHO_SEQUENCER -- requirements
Module: rho_sequencer

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1, meaning lane-memory read latency in cycles (legal 1..3).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request to run one full rho pass over 25 lanes.
REQ-005 The block SHALL have port abort, input, 1, which cancels the pass in progress.
REQ-006 The block SHALL have port lane_addr, output, 5, the lane index 0..24 for the current read or write.
REQ-007 The block SHALL have port lane_rd_en, output, 1, a one-cycle lane read strobe.
REQ-008 The block SHALL have port lane_rdata, input, 64, lane data, valid exactly RD_LAT cycles after lane_rd_en.
REQ-009 The block SHALL have port lane_wr_en, output, 1, a one-cycle lane write strobe.
REQ-010 The block SHALL have port lane_wdata, output, 64, the rotated lane data, valid while lane_wr_en=1.
REQ-011 The block SHALL have port busy, output, 1, high from the cycle after start is accepted until the pass ends.
REQ-012 The block SHALL have port co, output, 1, a one-cycle pass-complete pulse.

Function
REQ-013 The FSM SHALL have states IDLE, READ, WAIT, WRITE and DONE.
REQ-014 IDLE: start=1 SHALL set the lane counter to 0 and go to READ; start is ignored in all other states.
REQ-015 READ: lane_rd_en=1 and lane_addr=lane counter for one cycle, then WAIT.
REQ-016 WAIT: the block SHALL count RD_LAT cycles and capture lane_rdata into a 64-bit register at the end of cycle t+RD_LAT (t = READ cycle), then go to WRITE.
REQ-017 WRITE: lane_wr_en=1, lane_addr=same lane, lane_wdata = captured data rotated by off[lane], bit k = in[(k - off) mod 64].
REQ-018 Offsets off[0..24] SHALL be 21,8,41,45,15,56,14,18,2,61,28,27,0,1,62,55,20,36,44,6,25,39,3,10,43, held in a constant ROM.
REQ-019 After WRITE, the block SHALL go to READ with lane+1 if lane<24, else to DONE; lanes are processed in ascending order.
REQ-020 Each lane SHALL take RD_LAT+2 cycles, so a full pass is 25*(RD_LAT+2) cycles (75 at RD_LAT=1).
REQ-021 DONE: co=1 for exactly one cycle, busy=0 in that cycle, then IDLE; start is accepted again from the following cycle.
REQ-022 lane_rd_en and lane_wr_en SHALL never be high in the same cycle.
REQ-023 abort=1 in any non-IDLE state SHALL go to IDLE at the next edge; a write scheduled for that cycle is suppressed (lane_wr_en=0), and co is not pulsed.
REQ-024 If abort and start are both 1 in IDLE, start SHALL be ignored.
REQ-025 Outside READ and WRITE, lane_addr SHALL hold its last value and lane_wdata SHALL be don't-care.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, lane counter 0, capture register 0, and lane_rd_en=lane_wr_en=busy=co=0, lane_addr=0.
REQ-027 Reset asserted mid-pass SHALL abandon the pass with no further memory strobes; lanes already written stay written.

Configuration
REQ-028 With macro RHO_ZERO_SKIP_EN defined, any lane whose offset is 0 (lane 12) SHALL be skipped, with no read or write, and the counter advancing directly, so a pass is 24*(RD_LAT+2) cycles.
REQ-029 Without RHO_ZERO_SKIP_EN, every lane including lane 12 SHALL be read and written back unchanged.

Verification
REQ-030 RD_LAT=1, start, lane 0 rdata=0x0000000000000001 -> lane 0 write data 0x0000000000200000; co rises 75 cycles after start is accepted.
REQ-031 Lane 14 rdata=0x0000000000000001 -> write data 0x4000000000000000; lane 9 rdata=0x8000000000000000 -> write data 0x1000000000000000.
REQ-032 RD_LAT=3 -> lane_rd_en to lane_wr_en spacing of 4 cycles, pass length 125 cycles, one co pulse.
REQ-033 abort in the WRITE cycle of lane 5 -> no lane 5 write, busy=0 next cycle, no co, and a subsequent start restarts at lane 0.
REQ-034 rst_n dropped in the WAIT state of lane 3 -> all outputs 0 in the same cycle, IDLE after release; start asserted during busy -> no effect on sequence.
REQ-035 With RHO_ZERO_SKIP_EN -> no strobe with lane_addr=12, pass length 72 cycles at RD_LAT=1; without it -> lane 12 data written back identical.
